norm_row_packer: RTL and testbench
==================================

Name: norm_row_packer

Overview:
- Sits directly downstream of the dual-core normalizer.
- Consumes one pair of normalized psums (core1 lane, core2 lane) per norm_valid beat.
- Requantizes each word by rounding right-shift plus signed saturation, and packs COL beats into one full output row.
- Completed rows are queued in a small FIFO and drained over a valid/ready interface toward the output SRAM writer.

Parameters:
W_IN, 11, width of psum_norm_1/psum_norm_2 (signed two's complement)
COL, 8, beats per row (columns per core); row holds 2*COL words
W_OUT, 8, width of each requantized output word (signed)
SHIFT, 3, arithmetic right shift applied before saturation (0 allowed)
DEPTH, 4, FIFO depth in rows (power of 2, >=2)
IDX_W, 8, width of row index counter

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
norm_valid  in  1  beat strobe from normalizer
psum_norm_1  in  W_IN  core1 normalized psum
psum_norm_2  in  W_IN  core2 normalized psum
flush  in  1  close current partial row, zero-padding unfilled lanes
clr_overflow  in  1  clears sticky overflow
in_ready  out  1  advisory: high when FIFO not full; normalizer has no stall, so it is not a handshake
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid&&out_ready
out_data  out  2*COL*W_OUT  packed row; lane k at bits [k*W_OUT +: W_OUT]
out_partial  out  1  head row was closed by flush before COL beats
out_row_idx  out  IDX_W  sequence number of head row
overflow  out  1  sticky: a completed row was dropped because FIFO full

Behaviour:
- Reset (reset==0, async): beat_cnt=0, staging row=0, FIFO empty.
- Reset output values: out_valid=0, out_data=0, out_partial=0, out_row_idx=0, overflow=0, in_ready=1. Row counter=0. Reset mid-row discards partial row and FIFO contents.
- Requantize, per word, combinational on the input:
  - t = x + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at W_IN+1 bits signed.
  - y = t >>> SHIFT.
  - Saturate y to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- Packing on beat k = beat_cnt: psum_norm_1 goes to lane k, psum_norm_2 goes to lane COL+k. beat_cnt increments.
- Row close:
  - A norm_valid beat with beat_cnt==COL-1 closes the row. Lanes 0..COL-1 and COL..2COL-1 are all filled; out_partial=0.
  - flush with beat_cnt>0 also closes the row. Unfilled lanes are 0; out_partial=1.
  - On close: row, partial flag, and row counter are pushed that same edge. beat_cnt→0, staging row cleared, row counter +1 (wraps mod 2^IDX_W).
- Simultaneous flush+norm_valid: the beat is packed first, then the row closes. out_partial=1 unless that beat was lane COL-1, in which case it is a normal full row with out_partial=0.
- flush with beat_cnt==0 and no norm_valid: no-op; no empty row is pushed.
- Latency: closing edge at cycle t → out_valid=1 at t+1 if FIFO was empty. No combinational input→output path.
- FIFO:
  - Push allowed if not full, OR if full with a pop on the same edge (out_valid&&out_ready).
  - If push is not allowed, the row is dropped, overflow←1, and the row counter still increments (gap visible to consumer).
  - Pop on out_valid&&out_ready. Head data is held stable while out_valid&&!out_ready.
  - Pointers wrap mod DEPTH; full/empty use an extra pointer bit.
- overflow stays 1 until clr_overflow. Same-edge set and clear: set wins.
- in_ready = !full.
- States: FILL (beat_cnt 0..COL-1) only. No idle stall; beats are accepted every cycle unconditionally.

Test Plan:
- Full row, all quantize cases (SHIFT=3, W_OUT=8):
  - Stimulus: 8 consecutive beats; psum_norm_1 = 12, -12, -13, 1023, -1024, 0, 7, 3; psum_norm_2 = beat index ×8. out_ready=1.
  - Required: one row with lanes 0..7 = 2, -1, -2, 127, -128, 0, 1, 0 and lanes 8..15 = 0..7. out_partial=0, out_row_idx=0. out_valid rises exactly 1 cycle after beat 8.
- Flush:
  - 3 beats, then flush → out_partial=1, lanes 3..7 and 11..15 = 0.
  - flush at beat_cnt==0 → no row.
  - flush together with beat 8 → out_partial=0.
- Backpressure/overflow (DEPTH=4):
  - out_ready=0 for 5 full rows → FIFO holds idx 0..3, row 4 dropped, overflow=1, in_ready=0.
  - Then drain → idx 0,1,2,3 in order with data stable while stalled.
  - Next row carries idx 5.
- Full with concurrent pop: FIFO full, out_ready=1 on the closing edge of row 4 → row accepted, overflow stays 0.
- Reset mid-row: assert reset low after 5 beats with 2 rows queued → all outputs return to reset values; next row after release is idx 0, lanes filled from 0.
- Sticky clear: clr_overflow in the same cycle as a new drop → overflow remains 1; a later clr_overflow alone → overflow goes to 0.

Source files
------------

// File: rtl/norm_row_packer.sv
`default_nettype none
// ============================================================================
// Module   : norm_row_packer
// Purpose  : Requantizes pairs of normalized psums (rounding right shift plus
//            signed saturation), packs COL beats into one 2*COL-word row and
//            queues completed rows in a small FIFO drained over valid/ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   norm_valid    in   beat strobe from the normalizer (never stalled)
//   psum_norm_1   in   core1 psum, lanes 0..COL-1
//   psum_norm_2   in   core2 psum, lanes COL..2*COL-1
//   flush         in   close the current partial row (unfilled lanes = 0)
//   clr_overflow  in   clear the sticky overflow flag
//   in_ready      out  advisory FIFO-not-full indication
//   out_valid     out  FIFO head valid
//   out_ready     in   consumer accepts head on out_valid && out_ready
//   out_data      out  packed head row, lane k at [k*W_OUT +: W_OUT]
//   out_partial   out  head row was closed by flush before COL beats
//   out_row_idx   out  sequence number of head row
//   overflow      out  sticky: a completed row was dropped (FIFO full)
// ============================================================================
module norm_row_packer #(
  parameter int W_IN  = 11,
  parameter int COL   = 8,
  parameter int W_OUT = 8,
  parameter int SHIFT = 3,
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     norm_valid,
  input  logic [W_IN-1:0]          psum_norm_1,
  input  logic [W_IN-1:0]          psum_norm_2,
  input  logic                     flush,
  input  logic                     clr_overflow,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*COL*W_OUT-1:0]   out_data,
  output logic                     out_partial,
  output logic [IDX_W-1:0]         out_row_idx,
  output logic                     overflow
);

  localparam int ROW_W   = 2 * COL * W_OUT;
  localparam int CNT_W   = (COL > 1) ? $clog2(COL) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  // Half an LSB of the shifted result; evaluates to 0 when SHIFT == 0.
  localparam int RND     = (2 ** SHIFT) / 2;
  localparam int SAT_MAX = (2 ** (W_OUT - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W_OUT - 1));

  // Round-half-up arithmetic shift, then clamp to the signed output range.
  function automatic logic [W_OUT-1:0] requant(input logic [W_IN-1:0] x);
    logic signed [W_IN:0] t;
    logic signed [W_IN:0] y;
    int                   yi;
    t  = $signed({x[W_IN-1], x}) + $signed((W_IN+1)'(RND));
    y  = t >>> SHIFT;
    yi = int'(y);
    if (yi > SAT_MAX)      requant = W_OUT'(SAT_MAX);
    else if (yi < SAT_MIN) requant = W_OUT'(SAT_MIN);
    else                   requant = W_OUT'(yi);
  endfunction

  // --------------------------------------------------------------------------
  // Staging row
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_beat;
  logic [ROW_W-1:0] r_row;
  logic [IDX_W-1:0] r_row_idx;
  logic             r_overflow;

  logic [W_OUT-1:0] w_q1;
  logic [W_OUT-1:0] w_q2;
  logic [ROW_W-1:0] w_row_next;
  logic             w_last;
  logic             w_close;
  logic             w_partial;

  assign w_q1   = requant(psum_norm_1);
  assign w_q2   = requant(psum_norm_2);
  assign w_last = (r_beat == CNT_W'(COL - 1));

  // A beat that lands in the last lane always yields a full row, even when
  // flush arrives on the same cycle.
  assign w_close   = (norm_valid && w_last) ||
                     (flush && (norm_valid || (r_beat != '0)));
  assign w_partial = !(norm_valid && w_last);

  // Row as it looks after this cycle's beat; this is also what gets pushed
  // on a closing edge, so the final beat is included in the pushed row.
  always_comb begin
    w_row_next = r_row;
    if (norm_valid) begin
      w_row_next[int'(r_beat)*W_OUT +: W_OUT]         = w_q1;
      w_row_next[(COL+int'(r_beat))*W_OUT +: W_OUT]   = w_q2;
    end
  end

  // --------------------------------------------------------------------------
  // Row FIFO (extra pointer bit separates full from empty)
  // --------------------------------------------------------------------------
  logic [PTR_W:0]     r_wptr;
  logic [PTR_W:0]     r_rptr;
  logic [ROW_W-1:0]   r_mem_data [DEPTH];
  logic               r_mem_part [DEPTH];
  logic [IDX_W-1:0]   r_mem_idx  [DEPTH];

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [PTR_W-1:0]   w_waddr;
  logic [PTR_W-1:0]   w_raddr;

  assign w_waddr = r_wptr[PTR_W-1:0];
  assign w_raddr = r_rptr[PTR_W-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (w_waddr == w_raddr);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still takes the row when the head leaves on the same edge.
  assign w_push  = w_close && (!w_full || w_pop);
  assign w_drop  = w_close && !w_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat     <= '0;
      r_row      <= '0;
      r_row_idx  <= '0;
      r_overflow <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_close) begin
        r_beat    <= '0;
        r_row     <= '0;
        // Dropped rows still consume an index so the consumer sees the gap.
        r_row_idx <= r_row_idx + IDX_W'(1);
      end else if (norm_valid) begin
        r_beat <= r_beat + CNT_W'(1);
        r_row  <= w_row_next;
      end

      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);

      // Set has priority over a same-edge clear.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[w_waddr] <= w_row_next;
      r_mem_part[w_waddr] <= w_partial;
      r_mem_idx[w_waddr]  <= r_row_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all derived from registers)
  // --------------------------------------------------------------------------
  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? '0   : r_mem_data[w_raddr];
  assign out_partial = w_empty ? 1'b0 : r_mem_part[w_raddr];
  assign out_row_idx = w_empty ? '0   : r_mem_idx[w_raddr];
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_norm_row_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_row_packer
// Purpose  : Self-checking bench for norm_row_packer. The driver pushes the
//            expected row into a queue as stimulus is issued; a monitor pops
//            and compares whenever the DUT hands a row over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_row_packer;

  localparam int W_IN  = 11;
  localparam int COL   = 8;
  localparam int W_OUT = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int ROW_W = 2 * COL * W_OUT;

  logic               clk;
  logic               reset;
  logic               norm_valid;
  logic [W_IN-1:0]    psum_norm_1;
  logic [W_IN-1:0]    psum_norm_2;
  logic               flush;
  logic               clr_overflow;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_data;
  logic               out_partial;
  logic [IDX_W-1:0]   out_row_idx;
  logic               overflow;

  norm_row_packer #(
    .W_IN(W_IN), .COL(COL), .W_OUT(W_OUT), .SHIFT(3), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .norm_valid(norm_valid),
    .psum_norm_1(psum_norm_1), .psum_norm_2(psum_norm_2),
    .flush(flush), .clr_overflow(clr_overflow), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_partial(out_partial), .out_row_idx(out_row_idx), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ROW_W-1:0] data;
    logic             partial;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [ROW_W-1:0] got,
                     input logic [ROW_W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Row pattern: beat k of row r carries value v = 16r+k+1 scaled by 8, so
  // with SHIFT=3 rounding it requantizes exactly to v (core1) and -v (core2).
  function automatic logic [ROW_W-1:0] mk_row(input int r, input int n);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      v[k*W_OUT +: W_OUT]       = W_OUT'(16*r + k + 1);
      v[(COL+k)*W_OUT +: W_OUT] = W_OUT'(-(16*r + k + 1));
    end
    return v;
  endfunction

  task automatic push_exp(input logic [ROW_W-1:0] d, input logic p, input int idx);
    exp_t x;
    x.data = d; x.partial = p; x.idx = IDX_W'(idx);
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int r, input int k, input logic fl);
    norm_valid  = 1'b1;
    psum_norm_1 = W_IN'(8 * (16*r + k + 1));
    psum_norm_2 = W_IN'(-8 * (16*r + k + 1));
    flush       = fl;
    tick();
    norm_valid  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic send_row(input int r, input int n, input logic fl_last);
    for (int k = 0; k < n; k++) beat(r, k, fl_last && (k == n-1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_done", ROW_W'(q.size() == 0 && !out_valid), ROW_W'(1));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"},   ROW_W'(out_valid),   '0);
    chk({tag, "_out_data"},    out_data,            '0);
    chk({tag, "_out_partial"}, ROW_W'(out_partial), '0);
    chk({tag, "_out_row_idx"}, ROW_W'(out_row_idx), '0);
    chk({tag, "_overflow"},    ROW_W'(overflow),    '0);
    chk({tag, "_in_ready"},    ROW_W'(in_ready),    ROW_W'(1));
  endtask

  // Scoreboard monitor: the handshake is sampled mid-cycle, the pop itself
  // happens on the following rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_row: got row idx %0d, expected no row", out_row_idx);
      end else begin
        e = q.pop_front();
        chk("row_data",    out_data,            e.data);
        chk("row_partial", ROW_W'(out_partial), ROW_W'(e.partial));
        chk("row_idx",     ROW_W'(out_row_idx), ROW_W'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  int               p1 [8] = '{12, -12, -13, 1023, -1024, 0, 7, 3};
  int               e1 [8] = '{2, -1, -2, 127, -128, 0, 1, 0};
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] d0;

  initial begin
    reset = 1'b0; norm_valid = 1'b0; psum_norm_1 = '0; psum_norm_2 = '0;
    flush = 1'b0; clr_overflow = 1'b0; out_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    tick();
    reset = 1'b1;

    // ---- Full row covering every quantize case ----
    out_ready = 1'b1;
    row = '0;
    for (int k = 0; k < COL; k++) begin
      row[k*W_OUT +: W_OUT]       = W_OUT'(e1[k]);
      row[(COL+k)*W_OUT +: W_OUT] = W_OUT'(k);
    end
    push_exp(row, 1'b0, 0);
    for (int k = 0; k < COL; k++) begin
      norm_valid  = 1'b1;
      psum_norm_1 = W_IN'(p1[k]);
      psum_norm_2 = W_IN'(8 * k);
      tick();
      norm_valid  = 1'b0;
      if (k == COL-2) chk("latency_before_close", ROW_W'(out_valid), '0);
      if (k == COL-1) chk("latency_after_close",  ROW_W'(out_valid), ROW_W'(1));
    end
    wait_drain();

    // ---- Flush after 3 beats ----
    push_exp(mk_row(0, 3), 1'b1, 1);
    send_row(0, 3, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_drain();

    // ---- Flush with empty staging row: nothing pushed ----
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (3) tick();
    chk("flush_empty_no_row", ROW_W'(out_valid), '0);

    // ---- Flush on the 8th beat: full row ----
    push_exp(mk_row(1, 8), 1'b0, 2);
    send_row(1, 8, 1'b1);
    wait_drain();

    // ---- Backpressure and overflow ----
    pulse_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      if (r < DEPTH) push_exp(mk_row(r, 8), 1'b0, r);
      send_row(r, 8, 1'b0);
    end
    chk("ovf_set",        ROW_W'(overflow),  ROW_W'(1));
    chk("ovf_in_ready",   ROW_W'(in_ready),  '0);
    chk("ovf_out_valid",  ROW_W'(out_valid), ROW_W'(1));
    d0 = out_data;
    chk("stall_head", d0, mk_row(0, 8));
    repeat (3) tick();
    chk("stall_stable", out_data, d0);
    out_ready = 1'b1;
    wait_drain();
    push_exp(mk_row(5, 8), 1'b0, 5);
    send_row(5, 8, 1'b0);
    wait_drain();

    // ---- Full FIFO with a pop on the closing edge ----
    pulse_reset();
    out_ready = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      push_exp(mk_row(r, 8), 1'b0, r);
      send_row(r, 8, 1'b0);
    end
    chk("full_in_ready", ROW_W'(in_ready), '0);
    push_exp(mk_row(4, 8), 1'b0, 4);
    send_row(4, 7, 1'b0);
    out_ready = 1'b1;
    beat(4, 7, 1'b0);
    chk("concurrent_pop_no_ovf", ROW_W'(overflow), '0);
    wait_drain();

    // ---- Sticky overflow: set beats clear, then clear alone ----
    pulse_reset();
    out_ready = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      push_exp(mk_row(r, 8), 1'b0, r);
      send_row(r, 8, 1'b0);
    end
    send_row(4, 7, 1'b0);
    clr_overflow = 1'b1;
    beat(4, 7, 1'b0);
    clr_overflow = 1'b0;
    chk("sticky_set_wins", ROW_W'(overflow), ROW_W'(1));
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("sticky_clear", ROW_W'(overflow), '0);
    out_ready = 1'b1;
    wait_drain();

    // ---- Reset mid-row with rows queued ----
    out_ready = 1'b0;
    send_row(0, 8, 1'b0);
    send_row(1, 8, 1'b0);
    send_row(2, 5, 1'b0);
    chk("pre_reset_valid", ROW_W'(out_valid), ROW_W'(1));
    reset = 1'b0;
    #2;
    chk_reset_outputs("midrow_reset");
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    push_exp(mk_row(3, 8), 1'b0, 0);
    send_row(3, 8, 1'b0);
    wait_drain();

    chk("scoreboard_empty", ROW_W'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
